multiply_float: RTL and testbench

- Sequential IEEE-754 single-precision multiplier. Handshake is start/done, matching reciprocal_float.
- Sits directly downstream of reciprocal_float in the divide path: takes the reciprocal output `out` on operand b and the dividend on operand a, and produces a*(1/b).
- Uses an iterative shift-add mantissa multiply, so area stays small, like the CORDIC stages.

---
 rtl/multiply_float.sv | 215 +++++++++++++++++++++
 tb/tb_multiply_float.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiply_float.sv
// multiply_float: sequential IEEE-754 single-precision multiplier.
// It sits after reciprocal_float in the divide path and computes a*(1/b).
// The mantissa multiply is an iterative shift-add that retires BITS_PER_CYCLE
// multiplier bits per iteration. Rounding is round-to-nearest-even.
// Subnormal inputs are read as zero, and subnormal results flush to zero.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset; aborts an operation in flight
//   start      launch request; only a rising level launches, and only from IDLE
//   a, b       fp32 operands, captured at the accept edge
//   out        fp32 product, registered and held until the next done
//   done       one-cycle pulse; out and the flags are valid in the same cycle
//   busy       high from accept through the done cycle
//   zero_flag  result is +-0, including underflow flush
//   inf_flag   result is +-inf, including overflow
//   nan_flag   result is NaN
module multiply_float #(
    parameter int BITS_PER_CYCLE = 1    // 1, 2, 4 or 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] out,
    output logic        done,
    output logic        busy,
    output logic        zero_flag,
    output logic        inf_flag,
    output logic        nan_flag
);

    localparam int B = BITS_PER_CYCLE;
    localparam int N = 24 / B;
    localparam logic [4:0] LAST_ITER = 5'(N - 1);

    typedef enum logic [2:0] {IDLE, UNPACK, MUL, NORM, ROUND, DONE} state_t;

    state_t state, state_next;

    logic               start_d;
    logic               accept;
    logic [31:0]        a_r, b_r;
    logic               sign;
    logic signed [9:0]  e;
    logic [23:0]        ma;         // multiplicand mantissa with the hidden bit
    logic [47:0]        p;          // upper half: partial sum; lower half: remaining multiplier bits
    logic [4:0]         cnt;
    logic [23:0]        m;
    logic               guard, sticky;
    logic               special;
    logic [31:0]        spec_out;
    logic               spec_nan, spec_inf, spec_zero;

    assign accept = (state == IDLE) && start && !start_d;

    // ---------------- operand classification (valid in UNPACK) ----------------
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, res_sign;
    logic        s_nan, s_inf, s_zero, is_special;
    logic [31:0] s_out;

    // NOTE: every signal driven here gets a value on every path, which keeps the block free of inferred latches.
    always_comb begin
        // Exponent 0 covers both true zero and subnormals (inputs read as zero).
        a_zero     = (a_r[30:23] == 8'h00);
        b_zero     = (b_r[30:23] == 8'h00);
        a_inf      = (a_r[30:23] == 8'hFF) && (a_r[22:0] == 23'h0);
        b_inf      = (b_r[30:23] == 8'hFF) && (b_r[22:0] == 23'h0);
        a_nan      = (a_r[30:23] == 8'hFF) && (a_r[22:0] != 23'h0);
        b_nan      = (b_r[30:23] == 8'hFF) && (b_r[22:0] != 23'h0);
        res_sign   = a_r[31] ^ b_r[31];

        s_nan      = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
        s_inf      = !s_nan && (a_inf || b_inf);
        s_zero     = !s_nan && !s_inf && (a_zero || b_zero);
        is_special = s_nan || s_inf || s_zero;

        s_out = {res_sign, 31'h0};
        if (s_nan)
            s_out = 32'h7FC0_0000;
        else if (s_inf)
            s_out = {res_sign, 8'hFF, 23'h0};
    end

    // ---------------- one shift-add iteration ----------------
    // The new partial sum is ma * (low B multiplier bits) plus the old upper half.
    // It fits in 24+B bits. Shifting it in above p[23:B] retires those B bits.
    logic [23+B:0] partial, mul_sum;

    always_comb begin
        partial = (24+B)'(ma) * (24+B)'(p[B-1:0]);
        mul_sum = (24+B)'(p[47:24]) + partial;
    end

    // ---------------- rounding and range check (valid in ROUND) ----------------
    logic              rnd_inc, r_inf, r_zero;
    logic [24:0]       rsum;
    logic signed [9:0] e_rnd;
    logic [31:0]       rnd_out;

    always_comb begin
        rnd_inc = guard && (sticky || m[0]);
        rsum    = {1'b0, m} + {24'h0, rnd_inc};
        // A carry out leaves rsum = 1.0 * 2, so its fraction bits are already zero.
        e_rnd   = rsum[24] ? e + 10'sd1 : e;
        r_inf   = (e_rnd >= 10'sd255);
        r_zero  = !r_inf && (e_rnd <= 10'sd0);
        rnd_out = {sign, e_rnd[7:0], rsum[22:0]};
        if (r_inf)
            rnd_out = {sign, 8'hFF, 23'h0};
        else if (r_zero)
            rnd_out = {sign, 31'h0};
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = UNPACK;
            // A special operand skips the multiply. It still passes through ROUND,
            // which registers the result, so done comes two edges after accept.
            UNPACK:  state_next = is_special ? ROUND : MUL;
            MUL:     if (cnt == LAST_ITER) state_next = NORM;
            NORM:    state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state != IDLE);
    end

    // ---------------- datapath ----------------
    // NOTE: only the externally visible registers are reset. The working registers
    // are always loaded in UNPACK before they are read, so they need no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= 32'h0;
            done      <= 1'b0;
            zero_flag <= 1'b0;
            inf_flag  <= 1'b0;
            nan_flag  <= 1'b0;
            start_d   <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments, so every branch sees pre-edge values.
            start_d <= start;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r <= a;
                        b_r <= b;
                    end
                end
                UNPACK: begin
                    sign      <= res_sign;
                    ma        <= {1'b1, a_r[22:0]};
                    p         <= {24'h0, 1'b1, b_r[22:0]};
                    e         <= $signed({2'b00, a_r[30:23]}) + $signed({2'b00, b_r[30:23]}) - 10'sd127;
                    cnt       <= 5'd0;
                    special   <= is_special;
                    spec_out  <= s_out;
                    spec_nan  <= s_nan;
                    spec_inf  <= s_inf;
                    spec_zero <= s_zero;
                end
                MUL: begin
                    p   <= {mul_sum, p[23:B]};
                    cnt <= cnt + 5'd1;
                end
                NORM: begin
                    // The product of two [1,2) mantissas lies in [1,4). Bit 47 marks the [2,4) case.
                    if (p[47]) begin
                        m      <= p[47:24];
                        guard  <= p[23];
                        sticky <= |p[22:0];
                        e      <= e + 10'sd1;
                    end else begin
                        m      <= p[46:23];
                        guard  <= p[22];
                        sticky <= |p[21:0];
                    end
                end
                ROUND: begin
                    done <= 1'b1;
                    if (special) begin
                        out       <= spec_out;
                        nan_flag  <= spec_nan;
                        inf_flag  <= spec_inf;
                        zero_flag <= spec_zero;
                    end else begin
                        out       <= rnd_out;
                        nan_flag  <= 1'b0;
                        inf_flag  <= r_inf;
                        zero_flag <= r_zero;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiply_float.sv
// tb_multiply_float: scoreboard bench for multiply_float.
// Stimulus pushes the hand-computed result, the flags and the expected latency into a queue.
// A monitor pops an entry on every done pulse and compares it.
module tb_multiply_float;

    localparam int BPC   = 1;
    localparam int LAT_N = 24 / BPC + 3;
    localparam int LAT_S = 2;

    // flag encoding {nan, inf, zero}
    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_NAN  = 3'b100;
    localparam logic [2:0] F_INF  = 3'b010;
    localparam logic [2:0] F_ZERO = 3'b001;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b, out;
    logic        done, busy, zero_flag, inf_flag, nan_flag;

    typedef struct {
        string       name;
        logic [31:0] out;
        logic [2:0]  flags;
        int          e0;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   done_count = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    multiply_float #(.BITS_PER_CYCLE(BPC)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .out       (out),
        .done      (done),
        .busy      (busy),
        .zero_flag (zero_flag),
        .inf_flag  (inf_flag),
        .nan_flag  (nan_flag)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input string name, input logic [31:0] eo, input logic [2:0] ef, input int lat);
        exp_t e;
        e.name  = name;
        e.out   = eo;
        e.flags = ef;
        e.e0    = cyc + 1;   // start is driven here, so the accept edge is the next rising edge
        e.lat   = lat;
        sb.push_back(e);
    endtask

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            done_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got out=%h with no operation pending", out);
            end else begin
                e = sb.pop_front();
                check({e.name, " out"}, out, e.out);
                check({e.name, " flags"}, {29'h0, nan_flag, inf_flag, zero_flag}, {29'h0, e.flags});
                check({e.name, " latency"}, cyc - e.e0, e.lat);
            end
        end
    end

    // Wait, with a cycle budget, for all pending expectations to be retired.
    task automatic wait_empty(input string name, output int busy_low);
        bit ok = 1'b0;
        busy_low = 0;
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            if (sb.size() != 0 && !busy) busy_low++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: %0d results pending, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eo, input logic [2:0] ef, input int lat);
        int busy_low;
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        push_exp(name, eo, ef, lat);
        @(negedge clk);
        start = 1'b0;
        if (!busy) busy_low = 1; else busy_low = 0;
        begin
            int bl;
            wait_empty(name, bl);
            busy_low += bl;
        end
        check({name, " busy_throughout"}, busy_low, 0);
    endtask

    initial begin
        int d0;
        rst   = 1'b1;
        start = 1'b0;
        a     = 32'h0;
        b     = 32'h0;
        repeat (3) @(negedge clk);
        check("reset out", out, 32'h0);
        check("reset done", {31'h0, done}, 32'h0);
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset flags", {29'h0, nan_flag, inf_flag, zero_flag}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // main function
        run_op("three_third",  32'h4040_0000, 32'h3EAA_AAAB, 32'h3F80_0000, F_NONE, LAT_N);
        run_op("five_fifth",   32'h40A0_0000, 32'h3E4C_CCCD, 32'h3F80_0000, F_NONE, LAT_N);
        run_op("neg_sign",     32'hC040_0000, 32'h4000_0000, 32'hC0C0_0000, F_NONE, LAT_N);
        run_op("tie_round_up", 32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, F_NONE, LAT_N);
        run_op("tie_round_dn", 32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004, F_NONE, LAT_N);

        // specials
        run_op("inf_times_zero", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, F_NAN,  LAT_S);
        run_op("neg_inf",        32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, F_INF,  LAT_S);
        run_op("neg_zero",       32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, F_ZERO, LAT_S);
        run_op("nan_operand",    32'h3F80_0000, 32'h7FC1_2345, 32'h7FC0_0000, F_NAN,  LAT_S);

        // range checks
        run_op("overflow",  32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, F_INF,  LAT_N);
        run_op("underflow", 32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, F_ZERO, LAT_N);
        run_op("daz",       32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, F_ZERO, LAT_S);

        // start held high for 40 cycles: exactly one done
        d0 = done_count;
        @(negedge clk);
        a = 32'h4040_0000;
        b = 32'h3EAA_AAAB;
        start = 1'b1;
        push_exp("hold_start", 32'h3F80_0000, F_NONE, LAT_N);
        repeat (40) @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("hold_start done_count", done_count - d0, 1);

        // start pulsed while busy: ignored
        d0 = done_count;
        @(negedge clk);
        a = 32'h40A0_0000;
        b = 32'h3E4C_CCCD;
        start = 1'b1;
        push_exp("busy_pulse", 32'h3F80_0000, F_NONE, LAT_N);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        a = 32'h3F80_0000;
        b = 32'h4000_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("busy_pulse done_count", done_count - d0, 1);

        // start pulsed after done: a second operation runs
        d0 = done_count;
        run_op("after_done", 32'hC040_0000, 32'h4000_0000, 32'hC0C0_0000, F_NONE, LAT_N);
        check("after_done done_count", done_count - d0, 1);

        // reset mid-operation: aborted with no done
        d0 = done_count;
        @(negedge clk);
        a = 32'h4040_0000;
        b = 32'h3EAA_AAAB;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_reset out", out, 32'h0);
        check("mid_reset busy", {31'h0, busy}, 32'h0);
        check("mid_reset flags", {29'h0, nan_flag, inf_flag, zero_flag}, 32'h0);
        repeat (35) @(negedge clk);
        check("mid_reset no_done", done_count - d0, 0);
        run_op("post_reset", 32'h4000_0000, 32'h3F00_0000, 32'h3F80_0000, F_NONE, LAT_N);

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
